serial_deserializer: RTL and testbench

Serial-in/parallel-out receiver; the receiving end of the team's parallel-load, MSB-first shift-out link. It collects DATA_WIDTH bits from a 1-bit stream, framed by a sync strobe on the first bit, and presents the assembled word with a one-cycle valid pulse. It is used wherever a word is shifted between blocks or off-chip, e.g. controller and score data in the game logic.

---
 rtl/serial_deserializer.sv | 165 ++++++++++++++++
 tb/tb_serial_deserializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// serial_deserializer
// Serial-in / parallel-out receiver for an MSB-first shift link. A frame
// starts with a sync strobe on its first bit. After DATA_WIDTH bits (plus one
// even-parity bit when PARITY_EN is defined) the assembled word appears on
// data_out together with a one-cycle data_valid pulse.
//
// Optional feature macro: PARITY_EN
//   defined   - each frame carries a trailing even-parity bit; parity_err is
//               registered and valid together with data_valid
//   undefined - frames are DATA_WIDTH bits long; parity_err is tied to 0
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   serial_in  in   serial data, MSB first
//   bit_en     in   sample serial_in this cycle
//   sync       in   (with bit_en) this bit is the first bit of a frame
//   data_out   out  last completed word, held until the next word completes
//   data_valid out  one-cycle pulse when data_out updates
//   busy       out  a frame is partially received
//   frame_err  out  one-cycle pulse when sync restarts a partial frame
//   parity_err out  parity result, valid with data_valid
module serial_deserializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  bit_en,
    input  logic                  sync,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  parity_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;
    logic                    busy_q, busy_d;
    logic                    frame_err_q, frame_err_d;
    logic                    parity_err_q, parity_err_d;
    logic [DATA_WIDTH-1:0]   shifted;

    assign shifted = {shreg_q[DATA_WIDTH-2:0], serial_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = parity_err_q;

        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    // Bits arriving outside a frame are dropped.
                    if (sync) begin
                        shreg_d = shifted;
                        cnt_d   = CNT_W'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_d = shifted;
                    if (sync) begin
                        // Restart wins even over a would-be last bit.
                        cnt_d       = CNT_W'(1);
                        frame_err_d = 1'b1;
                    end else if (cnt_q == LAST_CNT) begin
`ifdef PARITY_EN
                        // Word is complete; wait for the parity bit.
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = PARITY;
`else
                        data_out_d   = shifted;
                        data_valid_d = 1'b1;
                        cnt_d        = '0;
                        state_d      = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (sync) begin
                        shreg_d     = shifted;
                        cnt_d       = CNT_W'(1);
                        frame_err_d = 1'b1;
                        state_d     = SHIFT;
                    end else begin
                        // Parity bit is checked but not shifted into the word.
                        data_out_d   = shreg_q;
                        data_valid_d = 1'b1;
                        parity_err_d = (^shreg_q) ^ serial_in;
                        cnt_d        = '0;
                        state_d      = IDLE;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

`ifdef PARITY_EN
    assign parity_err = parity_err_q;
`else
    // The MSB is only needed for the parity check; without it, it simply
    // falls off the end of the shift register.
    logic shreg_msb_unused;
    logic parity_err_q_unused;
    assign shreg_msb_unused    = shreg_q[DATA_WIDTH-1];
    assign parity_err_q_unused = parity_err_q;
    assign parity_err          = 1'b0;
`endif

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_serial_deserializer.sv
module tb_serial_deserializer;

    localparam int W = 8;
`ifdef PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         serial_in;
    logic         bit_en;
    logic         sync;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         frame_err;
    logic         parity_err;

    serial_deserializer #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .bit_en     (bit_en),
        .sync       (sync),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] word;
        logic         perr;
    } exp_t;

    exp_t         sb[$];
    int           errors    = 0;
    int           checks    = 0;
    int           valid_cnt = 0;
    int           ferr_cnt  = 0;
    int           sent      = 0;
    logic [W-1:0] exp_dout  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every data_valid pops the oldest expected word.
    always @(negedge clk) begin
        if (data_valid) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_valid: observed data_out=%0h expected no valid", data_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data_out", 32'(data_out), 32'(e.word));
`ifdef PARITY_EN
                chk("parity_err", 32'(parity_err), 32'(e.perr));
`else
                chk("parity_err_tied", 32'(parity_err), 32'(1'b0));
`endif
                $display("word observed=%0h expected=%0h", data_out, e.word);
            end
        end
        if (frame_err) ferr_cnt++;
    end

    // Drive one cycle of inputs; return 1 ns after the sampling edge.
    task automatic step(input logic en, input logic s, input logic b);
        bit_en    = en;
        sync      = s;
        serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks(input string tag, input logic exp_busy);
        chk({tag, "_valid"}, 32'(data_valid), 32'(1'b0));
        chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        chk({tag, "_dout_hold"}, 32'(data_out), 32'(exp_dout));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(1'b0));
    endtask

    // Full frame, MSB first, sync on bit 1. Optional bit_en=0 gaps after
    // bit ga (gl cycles) and after bit gb (glb cycles); sync is held high in
    // the gaps to show it is ignored there.
    task automatic send_frame(input logic [W-1:0] w, input logic p,
                              input int ga, input int gl, input int gb, input int glb,
                              input logic restart);
        exp_t e;
        int   g;
        e.word = w;
        e.perr = (^w) ^ p;
        sb.push_back(e);
        sent++;
        for (int i = 0; i < W; i++) begin
            step(1'b1, (i == 0), w[W-1-i]);
            chk("frame_err", 32'(frame_err), 32'(restart && (i == 0)));
            if (i < W - 1 || FL > W) begin
                chk("busy_mid", 32'(busy), 32'(1'b1));
                chk("valid_mid", 32'(data_valid), 32'(1'b0));
            end else begin
                chk("busy_end", 32'(busy), 32'(1'b0));
                chk("valid_end", 32'(data_valid), 32'(1'b1));
                exp_dout = w;
            end
            g = (i + 1 == ga) ? gl : ((i + 1 == gb) ? glb : 0);
            for (int j = 0; j < g; j++) begin
                step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
                idle_checks("gap", 1'b1);
            end
        end
`ifdef PARITY_EN
        step(1'b1, 1'b0, p);
        chk("busy_par", 32'(busy), 32'(1'b0));
        chk("valid_par", 32'(data_valid), 32'(1'b1));
        exp_dout = w;
`endif
    endtask

    task automatic send_partial(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, (i == 0), w[W-1-i]);
            chk("busy_partial", 32'(busy), 32'(1'b1));
        end
    endtask

    initial begin
        int v0;
        int f0;
        reset     = 1'b1;
        serial_in = 1'b0;
        bit_en    = 1'b0;
        sync      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(data_out), 32'(0));
        chk("rst_valid", 32'(data_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ferr", 32'(frame_err), 32'(0));
        chk("rst_perr", 32'(parity_err), 32'(0));
        reset = 1'b0;

        // Bits without sync while idle are discarded.
        step(1'b1, 1'b0, 1'b1);
        idle_checks("idle_nosync", 1'b0);

        // 1: single word
        send_frame(8'hA5, ^8'hA5, 0, 0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        idle_checks("after_a5", 1'b0);

        // 2: back-to-back words, no gap
        f0 = ferr_cnt;
        send_frame(8'h3C, ^8'h3C, 0, 0, 0, 0, 1'b0);
        send_frame(8'hC3, ^8'hC3, 0, 0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        idle_checks("after_b2b", 1'b0);
        chk("b2b_no_ferr", 32'(ferr_cnt), 32'(f0));

        // 3: bit_en gaps
        send_frame(8'h81, ^8'h81, 3, 2, 6, 1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        idle_checks("after_gaps", 1'b0);

        // 4: partial frame restarted by sync
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_partial(8'hE0, 3);
        send_frame(8'h5A, ^8'h5A, 0, 0, 0, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        idle_checks("after_restart", 1'b0);
        chk("restart_one_valid", 32'(valid_cnt - v0), 32'(1));
        chk("restart_one_ferr", 32'(ferr_cnt - f0), 32'(1));

        // 5: reset mid-frame
        v0 = valid_cnt;
        send_partial(8'hB6, 5);
        reset = 1'b1;
        #1;
        exp_dout = '0;
        chk("arst_dout", 32'(data_out), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_valid", 32'(data_valid), 32'(0));
        chk("arst_ferr", 32'(frame_err), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (W) begin
            step(1'b1, 1'b0, 1'b1);
            idle_checks("post_rst", 1'b0);
        end
        chk("aborted_no_valid", 32'(valid_cnt - v0), 32'(0));
        send_frame(8'hFF, ^8'hFF, 0, 0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        idle_checks("after_ff", 1'b0);

`ifdef PARITY_EN
        // 6: parity good then bad
        send_frame(8'h07, 1'b1, 0, 0, 0, 0, 1'b0);
        send_frame(8'h07, 1'b0, 0, 0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        idle_checks("after_par", 1'b0);
`endif

        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'(0));
        chk("valid_total", 32'(valid_cnt), 32'(sent));
        chk("ferr_total", 32'(ferr_cnt), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
